// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants for the serial/parallel converters.
package sipo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with valid/ready holding register.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sin,
  input  logic                      clr,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      busy,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
  output logic                      overrun
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] r_sh, r_dout, w_word;
  logic [CW-1:0]    r_cnt;
  logic             r_vld, r_ovr, w_last, w_done, w_load;
  assign w_word  = MSB_FIRST ? {r_sh[WIDTH-2:0], sin} : {sin, r_sh[WIDTH-1:1]};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_done  = en && !clr && w_last;
  // a completed word may replace a held one only if it is accepted this same cycle
  assign w_load  = w_done && (!r_vld || dout_ready);
  assign dout       = r_dout;
  assign dout_valid = r_vld;
  assign overrun    = r_ovr;
  assign bit_cnt    = r_cnt;
  assign busy       = (r_cnt != '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (clr) begin
        r_sh  <= '0;
        r_cnt <= '0;
        r_ovr <= 1'b0;
      end else if (en) begin
        r_sh  <= w_last ? '0 : w_word;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        if (w_done && !w_load) r_ovr <= 1'b1;
      end
      if (w_load) begin
        r_dout <= w_word;
        r_vld  <= 1'b1;
      end else if (r_vld && dout_ready) begin
        r_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: MSB- and LSB-first instances driven in parallel against a queue-based model.
module tb_sipo_deser;
  import sipo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, sin = 1'b0, clr = 1'b0, rdy = 1'b1;
  logic [7:0] m_dout, l_dout;
  logic m_vld, l_vld, m_busy, l_busy, m_ovr, l_ovr;
  logic [2:0] m_cnt, l_cnt;
  int total = 0, bad = 0;
  bit q[$];
  logic [7:0] e_dm = '0, e_dl = '0;
  logic e_vld = 1'b0, e_ovr = 1'b0;
  typedef struct {
    logic r, e, s, c, d;
    logic [7:0] dout;
    logic vld, bsy;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[11];

  sipo_deser #(.WIDTH(8), .MSB_FIRST(MSB_FIRST_ORDER)) u_m (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .clr(clr), .dout(m_dout),
    .dout_valid(m_vld), .dout_ready(rdy), .busy(m_busy), .bit_cnt(m_cnt), .overrun(m_ovr));
  sipo_deser #(.WIDTH(8), .MSB_FIRST(LSB_FIRST_ORDER)) u_l (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .clr(clr), .dout(l_dout),
    .dout_valid(l_vld), .dout_ready(rdy), .busy(l_busy), .bit_cnt(l_cnt), .overrun(l_ovr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: collect arriving bits in a queue; a full queue becomes a word.
  task automatic model();
    logic [7:0] wm, wl;
    bit done;
    done = 0;
    if (rst) begin
      q.delete(); e_dm = '0; e_dl = '0; e_vld = 0; e_ovr = 0;
    end else begin
      if (clr) begin
        q.delete(); e_ovr = 0;
      end else if (en) begin
        q.push_back(sin);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = q[i];
            wl[i]   = q[i];
          end
          q.delete(); done = 1;
        end
      end
      if (done && (!e_vld || rdy)) begin
        e_dm = wm; e_dl = wl; e_vld = 1;
      end else begin
        if (done) e_ovr = 1;
        if (e_vld && rdy) e_vld = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("m_dout", 32'(m_dout), 32'(e_dm));
    chk("l_dout", 32'(l_dout), 32'(e_dl));
    chk("m_valid", 32'(m_vld), 32'(e_vld));
    chk("l_valid", 32'(l_vld), 32'(e_vld));
    chk("m_overrun", 32'(m_ovr), 32'(e_ovr));
    chk("l_overrun", 32'(l_ovr), 32'(e_ovr));
    chk("m_bit_cnt", 32'(m_cnt), 32'(q.size()));
    chk("l_bit_cnt", 32'(l_cnt), 32'(q.size()));
    chk("m_busy", 32'(m_busy), 32'(q.size() != 0));
    chk("l_busy", 32'(l_busy), 32'(q.size() != 0));
  endtask

  task automatic cyc(input logic r, input logic e, input logic s, input logic c, input logic d);
    rst = r; en = e; sin = s; clr = c; rdy = d;
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] w, input int gap, input logic rdy_o, input logic rdy_l);
    for (int i = 0; i < 8; i++) begin
      repeat (gap) cyc(0, 0, 1'($urandom), 0, rdy_o);
      cyc(0, 1, w[7-i], 0, (i == 7) ? rdy_l : rdy_o);
    end
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    tbl[0] = '{1, 0, 0, 0, 1, 8'h00, 0, 0, 3'd0};
    tbl[1] = '{1, 0, 0, 0, 1, 8'h00, 0, 0, 3'd0};
    for (int k = 0; k < 8; k++)
      tbl[2+k] = '{0, 1, a5[7-k], 0, 1, (k == 7) ? 8'hA5 : 8'h00, k == 7, k != 7, 3'((k + 1) % 8)};
    tbl[10] = '{0, 0, 0, 0, 1, 8'hA5, 0, 0, 3'd0};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].c, tbl[i].d);
      chk("tbl_dout", 32'(m_dout), 32'(tbl[i].dout));
      chk("tbl_ldout", 32'(l_dout), 32'(tbl[i].dout));
      chk("tbl_valid", 32'(m_vld), 32'(tbl[i].vld));
      chk("tbl_busy", 32'(m_busy), 32'(tbl[i].bsy));
      chk("tbl_cnt", 32'(m_cnt), 32'(tbl[i].cnt));
    end
    send(8'hA5, 3, 1, 1);
    chk("gap_dout", 32'(m_dout), 32'hA5);
    cyc(0, 0, 0, 0, 1);
    send(8'h3C, 0, 0, 0);
    send(8'hC3, 0, 0, 0);
    chk("ovr_dout", 32'(m_dout), 32'h3C);
    chk("ovr_flag", 32'(m_ovr), 32'h1);
    cyc(0, 0, 0, 0, 1);
    chk("ovr_accept_valid", 32'(m_vld), 32'h0);
    chk("ovr_sticky", 32'(m_ovr), 32'h1);
    cyc(0, 0, 0, 1, 0);
    chk("ovr_clr", 32'(m_ovr), 32'h0);
    send(8'h3C, 0, 0, 0);
    send(8'hC3, 0, 0, 1);
    chk("b2b_dout", 32'(m_dout), 32'hC3);
    chk("b2b_valid", 32'(m_vld), 32'h1);
    chk("b2b_ovr", 32'(m_ovr), 32'h0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'($urandom), 0, 1);
    cyc(0, 1, 1, 1, 1);
    chk("clr_cnt", 32'(m_cnt), 32'h0);
    send(8'h5A, 0, 1, 1);
    chk("clr_dout", 32'(m_dout), 32'h5A);
    send(8'hC0, 0, 1, 1);
    chk("lsb_dout", 32'(l_dout), 32'h03);
    chk("msb_dout", 32'(m_dout), 32'hC0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rst_cnt", 32'(l_cnt), 32'h0);
    chk("rst_valid", 32'(l_vld), 32'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0, ($urandom % 3) != 0, 1'($urandom),
          $urandom_range(0, 59) == 0, ($urandom % 4) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
